// File: rtl/ha_array_row_accum_seq.sv
// Sequencer around an unsigned 8x8 ha_array partial-product stage: captures the
// four row (b, t) vectors and reduces them one row per cycle into a saturated 16-bit product.
module ha_array_row_accum_seq #(
    parameter int TAG_W = 4,
    parameter int ROWS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       row_en,
    output logic [7:0]       mul_x,
    output logic [7:0]       mul_y,
    input  logic [6:0]       ha0_b,
    input  logic [6:0]       ha1_b,
    input  logic [6:0]       ha2_b,
    input  logic [6:0]       ha3_b,
    input  logic [8:0]       ha0_t,
    input  logic [8:0]       ha1_t,
    input  logic [8:0]       ha2_t,
    input  logic [8:0]       ha3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_p,
    output logic             out_sat,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       mul_x_r;
    logic [7:0]       mul_y_r;
    logic [TAG_W-1:0] tag_r;
    logic [3:0]       en_r;
    logic [6:0]       b_snap_r [ROWS];
    logic [8:0]       t_snap_r [ROWS];
    logic [6:0]       b_in_s   [ROWS];
    logic [8:0]       t_in_s   [ROWS];
    logic [1:0]       idx_r;
    logic [16:0]      acc_r;
    logic [16:0]      contrib_s;
    logic [16:0]      acc_sum_s;
    logic             out_valid_r;
    logic [15:0]      out_p_r;
    logic             out_sat_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             in_ready_r;
    logic             busy_r;

    // Weighted contribution of one row: (t + 4*b) placed at bit 2r, or zero when disabled.
    function automatic logic [16:0] row_contrib(input logic [6:0] b, input logic [8:0] t,
                                                input logic [1:0] r, input logic en);
        logic [9:0]  row_val;
        logic [16:0] shifted;
        row_val = {1'b0, t} + {1'b0, b, 2'b00};
        shifted = {7'd0, row_val} << {r, 1'b0};
        return en ? shifted : 17'd0;
    endfunction

    assign b_in_s[0] = ha0_b;
    assign b_in_s[1] = ha1_b;
    assign b_in_s[2] = ha2_b;
    assign b_in_s[3] = ha3_b;
    assign t_in_s[0] = ha0_t;
    assign t_in_s[1] = ha1_t;
    assign t_in_s[2] = ha2_t;
    assign t_in_s[3] = ha3_t;

    assign contrib_s = row_contrib(b_snap_r[idx_r], t_snap_r[idx_r], idx_r, en_r[idx_r]);
    assign acc_sum_s = acc_r + contrib_s;

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = CAPT;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPT: state_s = ACC;
            ACC: begin
                if (idx_r == 2'(ROWS - 1)) begin
                    state_s = DONE;
                end else begin
                    state_s = ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            busy_r     <= (state_s != IDLE);
        end
    end

    // Operand capture, row snapshot, serial accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_x_r     <= 8'd0;
            mul_y_r     <= 8'd0;
            tag_r       <= '0;
            en_r        <= 4'd0;
            idx_r       <= 2'd0;
            acc_r       <= 17'd0;
            out_valid_r <= 1'b0;
            out_p_r     <= 16'd0;
            out_sat_r   <= 1'b0;
            out_tag_r   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                b_snap_r[r] <= 7'd0;
                t_snap_r[r] <= 9'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mul_x_r <= in_x;
                        mul_y_r <= in_y;
                        tag_r   <= in_tag;
                        en_r    <= row_en;
                        acc_r   <= 17'd0;
                        idx_r   <= 2'd0;
                    end
                end
                CAPT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        b_snap_r[r] <= b_in_s[r];
                        t_snap_r[r] <= t_in_s[r];
                    end
                    idx_r <= 2'd0;
                end
                ACC: begin
                    acc_r <= acc_sum_s;
                    idx_r <= idx_r + 2'd1;
                    // The last row's sum goes straight into the result registers.
                    if (idx_r == 2'(ROWS - 1)) begin
                        out_valid_r <= 1'b1;
                        out_p_r     <= acc_sum_s[16] ? 16'hFFFF : acc_sum_s[15:0];
                        out_sat_r   <= acc_sum_s[16];
                        out_tag_r   <= tag_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign mul_x     = mul_x_r;
    assign mul_y     = mul_y_r;
    assign out_valid = out_valid_r;
    assign out_p     = out_p_r;
    assign out_sat   = out_sat_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_ha_array_row_accum_seq.sv
// Randomised self-checking bench for ha_array_row_accum_seq; the stage is a stub
// whose row vectors are chosen by the bench and scored from their bit weights.
module tb_ha_array_row_accum_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [3:0]  in_tag;
    logic [3:0]  row_en;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic [6:0]  hb [4];
    logic [8:0]  ht [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        out_sat;
    logic [3:0]  out_tag;
    logic        busy;

    int checks;
    int errors;

    ha_array_row_accum_seq #(.TAG_W(4), .ROWS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .row_en(row_en),
        .mul_x(mul_x), .mul_y(mul_y),
        .ha0_b(hb[0]), .ha1_b(hb[1]), .ha2_b(hb[2]), .ha3_b(hb[3]),
        .ha0_t(ht[0]), .ha1_t(ht[1]), .ha2_t(ht[2]), .ha3_t(ht[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_sat(out_sat), .out_tag(out_tag), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every set stub bit contributes its positional weight.
    function automatic int model_acc(input logic [3:0] en);
        int s;
        s = 0;
        for (int r = 0; r < 4; r++) begin
            if (en[r]) begin
                for (int k = 0; k < 9; k++) if (ht[r][k]) s += (1 << (k + 2 * r));
                for (int k = 0; k < 7; k++) if (hb[r][k]) s += (1 << (k + 2 + 2 * r));
            end
        end
        return s;
    endfunction

    task automatic set_stub(input logic [6:0] b, input logic [8:0] t);
        for (int r = 0; r < 4; r++) begin
            hb[r] = b;
            ht[r] = t;
        end
    endtask

    task automatic scramble_stub();
        for (int r = 0; r < 4; r++) begin
            hb[r] = 7'($urandom);
            ht[r] = 9'($urandom);
        end
    endtask

    // One operation; with hold>0 the result is backpressured and a second pair (x2) is offered.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [3:0] tag,
                          input logic [3:0] en, input int hold, input logic [7:0] x2);
        int acc;
        int edges;
        int waits;
        logic [15:0] exp_p;
        acc   = model_acc(en);
        exp_p = (acc > 65535) ? 16'hFFFF : 16'(acc);
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        check_val("ready_before_accept", {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        in_valid = 1'b1;
        in_x = x; in_y = y; in_tag = tag; row_en = en;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = 8'($urandom); in_y = 8'($urandom); row_en = 4'($urandom);
        check_val("mul_x", {24'd0, mul_x}, {24'd0, x});
        check_val("mul_y", {24'd0, mul_y}, {24'd0, y});
        check_val("busy_after_accept", {31'd0, busy}, 32'd1);
        check_val("in_ready_busy", {31'd0, in_ready}, 32'd0);
        edges = 1;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 2) scramble_stub();
            if (out_valid) break;
        end
        check_val("latency_edges", edges, 6);
        check_val("out_p", {16'd0, out_p}, {16'd0, exp_p});
        check_val("out_sat", {31'd0, out_sat}, {31'd0, acc > 65535});
        check_val("out_tag", {28'd0, out_tag}, {28'd0, tag});
        check_val("mul_x_hold", {24'd0, mul_x}, {24'd0, x});
        if (hold > 0) begin
            in_valid = 1'b1;
            in_x = x2;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_val("bp_valid", {31'd0, out_valid}, 32'd1);
                check_val("bp_p", {16'd0, out_p}, {16'd0, exp_p});
                check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check_val("bp_no_accept", {24'd0, mul_x}, {24'd0, x});
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_val("valid_drop", {31'd0, out_valid}, 32'd0);
        check_val("ready_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = 8'd0; in_y = 8'd0; in_tag = 4'd0; row_en = 4'd0;
        out_ready = 1'b1;
        set_stub(7'h55, 9'h0AA);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_mul_x", {24'd0, mul_x}, 32'd0);
        check_val("rst_mul_y", {24'd0, mul_y}, 32'd0);
        check_val("rst_out_p", {16'd0, out_p}, 32'd0);

        set_stub(7'h00, 9'h000);
        ht[0] = 9'h001;
        run_op(8'hA5, 8'h3C, 4'd5, 4'hF, 0, 8'h00);

        set_stub(7'h00, 9'h000);
        hb[3] = 7'h7F; ht[3] = 9'h1FF;
        run_op(8'h12, 8'h34, 4'd6, 4'hF, 0, 8'h00);

        set_stub(7'h7F, 9'h1FF);
        run_op(8'hFF, 8'hFF, 4'd7, 4'hF, 0, 8'h00);

        set_stub(7'h7F, 9'h1FF);
        run_op(8'hFE, 8'hFD, 4'd8, 4'b0111, 0, 8'h00);

        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) set_stub(7'h7F, 9'h1FF);
            else scramble_stub();
            run_op(8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 0, 8'h00);
        end

        // Backpressure, then the held pair is accepted and aborted by reset mid-ACC.
        set_stub(7'h3A, 9'h155);
        run_op(8'h5A, 8'hC3, 4'd9, 4'b1011, 10, 8'h77);
        @(posedge clk); #1;
        check_val("second_accept", {24'd0, mul_x}, 32'h77);
        check_val("second_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check_val("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        check_val("abort_idle_busy", {31'd0, busy}, 32'd0);

        set_stub(7'h01, 9'h003);
        run_op(8'h11, 8'h22, 4'd3, 4'hF, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ha_array_row_accum_seq.md
Name: ha_array_row_accum_seq

Overview:
- Multi-cycle sequencer that owns one combinational unsigned 8x8 ha_array partial-product stage: four rows, each a 7-bit b vector and a 9-bit t vector.
- Accepts operand pairs over a valid/ready handshake and drives the stage with registered operands.
- Snapshots the stage's eight row vectors, then reduces the rows with a single shared 17-bit adder, one row per cycle.
- Returns a 16-bit saturated product plus tag over a valid/ready handshake. Sits between operand producers and the accumulate/MAC pipeline.

Parameters:
TAG_W, 4, width of the request tag carried alongside each operand pair
ROWS, 4, number of ha_array rows reduced; fixed at 4, values other than 4 are illegal

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_x  input  8  multiplicand
in_y  input  8  multiplier
in_tag  input  TAG_W  request tag
row_en  input  4  per-row enable, sampled at accept; 0 = row contributes zero
mul_x  output  8  registered operand to ha_array stage x
mul_y  output  8  registered operand to ha_array stage y
ha0_b / ha1_b / ha2_b / ha3_b  input  7 each  row b vectors from stage
ha0_t / ha1_t / ha2_t / ha3_t  input  9 each  row t vectors from stage
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_p  output  16  reduced product, saturated
out_sat  output  1  accumulator exceeded 16'hFFFF
out_tag  output  TAG_W  tag of this result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release) clears everything:
  - state=IDLE
  - mul_x, mul_y, out_p, out_tag, acc = 0
  - out_valid = 0, out_sat = 0, busy = 0
  - in_ready = 1
- Row weight, for r = 0..3:
  - row_val[r] = t_r + (b_r << 2), 10 bits.
  - Contribution = row_val[r] << (2r), zero-extended to 17 bits; zero when row_en[r] = 0.
- Row bit weights:
  - t_r[k] has weight 2^(k+2r).
  - b_r[k] has weight 2^(k+2+2r).
- FSM states: IDLE, CAPT, ACC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register mul_x, mul_y, tag and row_en; clear acc and row index; go to CAPT.
- CAPT: one cycle for the combinational stage to settle. At the edge, snapshot all 8 row vectors into local registers and go to ACC with idx = 0.
- ACC:
  - Each edge: acc <= acc + contribution(idx); idx++.
  - After idx = 3 is added, go to DONE with out_valid = 1.
  - Exactly 4 ACC cycles regardless of row_en (fixed latency).
- DONE:
  - out_p = (acc > 16'hFFFF) ? 16'hFFFF : acc[15:0].
  - out_sat = acc[16].
  - out_p, out_sat and out_tag hold stable while out_valid & !out_ready.
  - On out_ready, out_valid drops and the FSM returns to IDLE.
- Latency: out_valid rises on the 6th rising edge counting the accept edge as edge 1.
- Throughput: one operation per 7 cycles minimum; no overlap of operations.
- in_ready is 0 in CAPT, ACC and DONE. in_valid during those states is ignored and not dropped; the producer must hold it.
- mul_x and mul_y hold their values from accept until the next accept. They do not toggle between operations.
- The 17-bit accumulator cannot overflow: maximum total is 1019*85 = 86615 < 2^17.
- Stage inputs change after the CAPT snapshot; they do not affect the result.
- Reset asserted mid-operation aborts it immediately:
  - No out_valid is produced.
  - in_ready = 1 after release.
- out_ready high while out_valid = 0 has no effect.

Test Plan:
- Reset sequence, all stage inputs driven from a stub → after release: in_ready=1, busy=0, out_valid=0, mul_x=0, mul_y=0.
- Accept x=8'hA5, y=8'h3C, tag=5; stub drives ha0_t=9'h001, all others 0, row_en=4'hF; out_ready=1 → mul_x=A5 and mul_y=3C from the edge after accept; out_valid on the 6th edge; out_p=16'h0001, out_tag=5, out_sat=0.
- Stub ha3_b=7'h7F, ha3_t=9'h1FF, others 0 → out_p=65216 (16'hFEC0), out_sat=0.
- All rows b=7'h7F, t=9'h1FF, row_en=4'hF → acc=86615, out_p=16'hFFFF, out_sat=1.
- Same max stimulus with row_en=4'b0111 → acc = 1019*21 = 21399, out_p=16'h5397, out_sat=0; latency unchanged (6 edges).
- Backpressure then reset:
  - out_ready=0 for 10 cycles → out_valid and out_p stable, in_ready=0, second in_valid not accepted.
  - Raise out_ready → second operand pair accepted on the cycle after return to IDLE.
  - Assert rst_n=0 during ACC → no out_valid, clean restart.
